spike_array_sched: RTL

SPIKE_ARRAY_SCHED -- requirements
Module: spike_array_sched

---
 rtl/spike_pkg.sv | 26 ++
 rtl/spike_array_sched_if.sv | 40 ++++
 rtl/spike_acc.sv | 49 ++++
 rtl/spike_array_sched.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// Shared definitions for the spike array scheduler: FSM encoding, default
// array latency and the 16-bit saturation limits used by spike_acc.
package spike_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_ARR_LAT = 11;
  localparam int          SAT_MAX         = 32767;
  localparam int          SAT_MIN         = -32768;

  // Clamp a signed 32-bit value into the signed 16-bit range, sign-extended.
  function automatic logic [31:0] sat16(input logic [31:0] x);
    if ($signed(x) > SAT_MAX) begin
      return 32'(SAT_MAX);
    end else if ($signed(x) < SAT_MIN) begin
      return 32'(SAT_MIN);
    end
    return x;
  endfunction

endpackage

// File: rtl/spike_array_sched_if.sv
// Command, operand-buffer, array and result signals of the spike scheduler.
// master = scheduler side, slave = environment side.
interface spike_array_sched_if #(
  parameter int unsigned N        = 128,
  parameter int unsigned BITWIDTH = 4,
  parameter int unsigned ADDR_W   = 10
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ADDR_W-1:0]       cmd_base;
  logic [ADDR_W-1:0]       cmd_chunks;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [N*4-1:0]          rd_weights;
  logic [N*BITWIDTH-1:0]   rd_acts;
  logic                    arr_start;
  logic [N*4-1:0]          arr_weights;
  logic [N*BITWIDTH-1:0]   arr_acts;
  logic                    arr_done;
  logic [15:0]             arr_result;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_data;
  logic                    busy;
  logic                    err;

  modport master (
    input  cmd_valid, cmd_base, cmd_chunks, rd_weights, rd_acts,
           arr_done, arr_result, out_ready,
    output cmd_ready, rd_en, rd_addr, arr_start, arr_weights, arr_acts,
           out_valid, out_data, busy, err
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_chunks, rd_weights, rd_acts,
           arr_done, arr_result, out_ready,
    input  cmd_ready, rd_en, rd_addr, arr_start, arr_weights, arr_acts,
           out_valid, out_data, busy, err
  );
endinterface

// File: rtl/spike_acc.sv
// Job accumulator: 32-bit wrapping sum of sign-extended 16-bit array results.
// Optional output clamp to 16-bit range when SPIKE_SCHED_SAT_EN is defined.
module spike_acc
  import spike_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        add_en_i,
  input  logic [15:0] add_val_i,
  output logic [31:0] out_data_o
);

  logic [31:0] acc_q, acc_d;
  logic [31:0] out_q, out_d;

  // Next accumulator value; clear wins over add.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_en_i) begin
      acc_d = acc_q + {{16{add_val_i[15]}}, add_val_i};
    end
  end

  // Result presented to the job output.
  always_comb begin
`ifdef SPIKE_SCHED_SAT_EN
    out_d = sat16(acc_d);
`else
    out_d = acc_d;
`endif
  end

  // Accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign out_data_o = out_q;

endmodule

// File: rtl/spike_array_sched.sv
// Spike array scheduler: accepts a job of C chunks, streams operand reads,
// drives the array one cycle later, sums the returned results and presents
// the job result. Build option: SPIKE_SCHED_SAT_EN (saturate result to 16 bit).
module spike_array_sched
  import spike_pkg::*;
#(
  parameter int unsigned N        = 128,
  parameter int unsigned BITWIDTH = 4,
  parameter int unsigned ARR_LAT  = DEFAULT_ARR_LAT,
  parameter int unsigned ADDR_W   = 10
) (
  input logic                 clk,
  input logic                 rst,
  spike_array_sched_if.master bus
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  // In-flight depth is bounded by the array pipeline; one spare bit of headroom.
  localparam int unsigned INFL_W = $clog2(ARR_LAT + 2) + 1;
  localparam int unsigned WGT_W  = N * 4;
  localparam int unsigned ACT_W  = N * BITWIDTH;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   iss_q, iss_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]    ret_q, ret_d;
  logic [INFL_W-1:0]   infl_q, infl_d;
  logic                rd_en_q, rd_en_d;
  logic                arr_start_q;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic                err_q, err_d;
  logic                acc_clr_c, done_ok_c;
  logic [WGT_W-1:0]    wgt_c;
  logic [ACT_W-1:0]    act_c;

  // Next-state, counters and output decode.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    iss_d     = iss_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    acc_clr_c = 1'b0;
    done_ok_c = bus.arr_done && (infl_q != '0);
    err_d     = err_q | (bus.arr_done && (infl_q == '0));
    infl_d    = infl_q + INFL_W'(arr_start_q) - INFL_W'(done_ok_c);
    ret_d     = ret_q + CNT_W'(done_ok_c);

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          count_d   = bus.cmd_chunks;
          rd_addr_d = bus.cmd_base;
          iss_d     = '0;
          ret_d     = '0;
          acc_clr_c = 1'b1;
          rd_en_d   = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (iss_q == count_q) begin
          state_d = ST_DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          iss_d     = iss_q + ADDR_W'(1);
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (ret_d == CNT_W'(count_q) + CNT_W'(1)) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (state_d == ST_OUT);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      iss_q       <= '0;
      rd_addr_q   <= '0;
      ret_q       <= '0;
      infl_q      <= '0;
      rd_en_q     <= 1'b0;
      arr_start_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      iss_q       <= iss_d;
      rd_addr_q   <= rd_addr_d;
      ret_q       <= ret_d;
      infl_q      <= infl_d;
      rd_en_q     <= rd_en_d;
      arr_start_q <= rd_en_q;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Buffer data arrives the cycle arr_start is high, so it passes straight through.
  assign wgt_c           = bus.rd_weights;
  assign act_c           = bus.rd_acts;
  assign bus.arr_weights = wgt_c;
  assign bus.arr_acts    = act_c;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.arr_start = arr_start_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

  spike_acc u_acc (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (acc_clr_c),
    .add_en_i   (done_ok_c),
    .add_val_i  (bus.arr_result),
    .out_data_o (bus.out_data)
  );

endmodule
